spi_burst_ctrl: RTL and testbench

Byte-burst sequencer that sits directly upstream of the 8-bit SPI master (CPOL=0, CPHA=0). It buffers outgoing bytes in a TX FIFO, issues one master transaction per byte via a start pulse, captures each received byte into an RX FIFO, and reports completion, RX overflow and slave timeout to the host logic. It lets software-side logic queue a multi-byte command without tracking per-byte handshakes.

---
 rtl/spi_burst_ctrl_pkg.sv | 15 +
 rtl/spi_byte_fifo.sv | 52 +++++
 rtl/spi_burst_ctrl.sv | 117 +++++++++++
 tb/tb_spi_burst_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_burst_ctrl_pkg.sv
// Shared definitions for the SPI byte-burst sequencer: FSM encoding and default sizing.
package spi_burst_ctrl_pkg;

  localparam int SPI_BYTE_W  = 8;
  localparam int DEF_DEPTH   = 8;
  localparam int DEF_TIMEOUT = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

endpackage

// File: rtl/spi_byte_fifo.sv
// Synchronous show-ahead byte FIFO with occupancy count; head reads as zero while empty.
module spi_byte_fifo
  import spi_burst_ctrl_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int DATA_W = SPI_BYTE_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     rd,
  output logic [DATA_W-1:0]        rdata,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic              full;
  logic              wr_ok;
  logic              rd_ok;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign wr_ok = wr && !full;
  assign rd_ok = rd && !empty;
  assign rdata = empty ? '0 : mem[rptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_ok) wptr <= wptr + 1'b1;
      if (rd_ok) rptr <= rptr + 1'b1;
      if (wr_ok && !rd_ok)      count <= count + 1'b1;
      else if (rd_ok && !wr_ok) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/spi_burst_ctrl.sv
// Byte-burst sequencer feeding an 8-bit SPI master: TX queue out, one start per byte, RX queue in.
module spi_burst_ctrl
  import spi_burst_ctrl_pkg::*;
#(
  parameter int DEPTH   = DEF_DEPTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tx_wr,
  input  logic [SPI_BYTE_W-1:0] tx_data,
  output logic                  tx_full,
  output logic [4:0]            tx_count,
  input  logic                  go,
  output logic                  busy,
  output logic                  done,
  output logic                  err_timeout,
  output logic                  rx_ovf,
  input  logic                  rx_rd,
  output logic [SPI_BYTE_W-1:0] rx_data,
  output logic                  rx_empty,
  output logic                  spi_start,
  output logic [SPI_BYTE_W-1:0] spi_data,
  input  logic [SPI_BYTE_W-1:0] spi_rx_data,
  input  logic                  spi_rx_ready
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_t                state;
  state_t                state_nx;
  logic [7:0]            wait_cnt;
  logic                  tx_rd;
  logic                  rx_wr;
  logic                  go_ok;
  logic                  timeout_hit;
  logic                  tx_empty;
  logic                  rx_full;
  logic [CW-1:0]         tx_cnt;
  logic [CW-1:0]         rx_cnt;
  logic [SPI_BYTE_W-1:0] tx_head;

  spi_byte_fifo #(.DEPTH(DEPTH), .DATA_W(SPI_BYTE_W)) u_tx_fifo (
    .clk(clk), .rst(rst), .wr(tx_wr), .wdata(tx_data), .rd(tx_rd),
    .rdata(tx_head), .empty(tx_empty), .count(tx_cnt)
  );

  spi_byte_fifo #(.DEPTH(DEPTH), .DATA_W(SPI_BYTE_W)) u_rx_fifo (
    .clk(clk), .rst(rst), .wr(rx_wr), .wdata(spi_rx_data), .rd(rx_rd),
    .rdata(rx_data), .empty(rx_empty), .count(rx_cnt)
  );

  assign tx_full  = (tx_cnt == CW'(DEPTH));
  assign rx_full  = (rx_cnt == CW'(DEPTH));
  assign tx_count = 5'(tx_cnt);

  always_comb begin
    state_nx    = state;
    tx_rd       = 1'b0;
    rx_wr       = 1'b0;
    go_ok       = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      ST_IDLE: begin
        if (go && !tx_empty) begin
          go_ok    = 1'b1;
          state_nx = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        tx_rd    = 1'b1;
        state_nx = ST_WAIT;
      end
      ST_WAIT: begin
        // A ready on the final counted cycle still wins over the timeout.
        if (spi_rx_ready) begin
          rx_wr    = 1'b1;
          state_nx = tx_empty ? ST_FIN : ST_ISSUE;
        end else if (wait_cnt == TIMEOUT_LAST) begin
          timeout_hit = 1'b1;
          state_nx    = ST_IDLE;
        end
      end
      ST_FIN:  state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      wait_cnt    <= '0;
      spi_start   <= 1'b0;
      spi_data    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_timeout <= 1'b0;
      rx_ovf      <= 1'b0;
    end else begin
      state       <= state_nx;
      spi_start   <= (state == ST_ISSUE);
      busy        <= (state != ST_IDLE);
      done        <= (state == ST_FIN);
      err_timeout <= timeout_hit;
      if (state == ST_ISSUE) begin
        spi_data <= tx_head;
        wait_cnt <= '0;
      end else if (state == ST_WAIT) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
      if (go_ok)                rx_ovf <= 1'b0;
      else if (rx_wr && rx_full) rx_ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_spi_burst_ctrl.sv
// Bench for spi_burst_ctrl: directed steps with random payloads, an echoing SPI master and a queue model.
module tb_spi_burst_ctrl;

  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 16;

  logic       clk;
  logic       rst;
  logic       tx_wr;
  logic [7:0] tx_data;
  logic       tx_full;
  logic [4:0] tx_count;
  logic       go;
  logic       busy;
  logic       done;
  logic       err_timeout;
  logic       rx_ovf;
  logic       rx_rd;
  logic [7:0] rx_data;
  logic       rx_empty;
  logic       spi_start;
  logic [7:0] spi_data;
  logic [7:0] spi_rx_data;
  logic       spi_rx_ready;

  spi_burst_ctrl #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .tx_wr(tx_wr), .tx_data(tx_data), .tx_full(tx_full),
    .tx_count(tx_count), .go(go), .busy(busy), .done(done), .err_timeout(err_timeout),
    .rx_ovf(rx_ovf), .rx_rd(rx_rd), .rx_data(rx_data), .rx_empty(rx_empty),
    .spi_start(spi_start), .spi_data(spi_data), .spi_rx_data(spi_rx_data),
    .spi_rx_ready(spi_rx_ready)
  );

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  bit master_on = 1'b1;
  int lat_max = 3;

  logic [7:0] sent_q[$];
  logic [7:0] exp_sent[$];
  logic [7:0] tx_m[$];
  logic [7:0] rx_m[$];
  bit         ovf_m = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=no_finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  always @(negedge clk) begin
    if (spi_start === 1'b1) sent_q.push_back(spi_data);
    if (done === 1'b1) done_cnt++;
    if (err_timeout === 1'b1) err_cnt++;
  end

  // SPI master stand-in: answers each start with the inverted byte after 1..lat_max cycles.
  initial begin : master
    int lat;
    logic [7:0] b;
    spi_rx_ready = 1'b0;
    spi_rx_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (spi_start === 1'b1 && master_on) begin
        b   = spi_data;
        lat = int'($urandom_range(1, lat_max));
        repeat (lat) @(posedge clk);
        #1 spi_rx_ready = 1'b1;
        spi_rx_data = ~b;
        @(posedge clk);
        #1 spi_rx_ready = 1'b0;
        spi_rx_data = 8'($urandom);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_tx(input logic [7:0] b);
    if (tx_m.size() < DEPTH) tx_m.push_back(b);
    tx_data = b;
    tx_wr   = 1'b1;
    @(posedge clk);
    #1 tx_wr = 1'b0;
  endtask

  task automatic do_go();
    go = 1'b1;
    @(posedge clk);
    #1 go = 1'b0;
  endtask

  // Completed burst: every queued byte goes out and its echo lands in RX unless RX is full.
  task automatic model_burst(input bit completes);
    int k;
    logic [7:0] b;
    k = completes ? tx_m.size() : 1;
    for (int i = 0; i < k; i++) begin
      b = tx_m.pop_front();
      exp_sent.push_back(b);
      if (completes) begin
        if (rx_m.size() < DEPTH) rx_m.push_back(~b);
        else ovf_m = 1'b1;
      end
    end
  endtask

  task automatic wait_end(input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && err_timeout !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_ends"}, 32'(n < 3000), 32'd1);
    chk({tag, "_busy_at_end"}, busy, 1'b1);
    @(negedge clk);
    chk({tag, "_busy_after"}, busy, 1'b0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_sent(input string tag);
    chk({tag, "_nsent"}, sent_q.size(), exp_sent.size());
    for (int i = 0; i < sent_q.size() && i < exp_sent.size(); i++)
      chk($sformatf("%s_sent%0d", tag, i), sent_q[i], exp_sent[i]);
    sent_q.delete();
    exp_sent.delete();
  endtask

  task automatic rx_drain(input string tag);
    int n;
    n = rx_m.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_rx_nonempty%0d", tag, i), rx_empty, 1'b0);
      chk($sformatf("%s_rx%0d", tag, i), rx_data, rx_m.pop_front());
      rx_rd = 1'b1;
      @(posedge clk);
      #1 rx_rd = 1'b0;
    end
    chk({tag, "_rx_empty"}, rx_empty, 1'b1);
  endtask

  initial begin : stim
    int n;
    int cyc;
    int d0;
    logic [7:0] b;
    rst = 1'b1; tx_wr = 1'b0; tx_data = 8'h00; go = 1'b0; rx_rd = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_full", tx_full, 1'b0);
    chk("rst_tx_count", tx_count, 5'd0);
    chk("rst_rx_empty", rx_empty, 1'b1);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err_timeout, 1'b0);
    chk("rst_ovf", rx_ovf, 1'b0);
    chk("rst_start", spi_start, 1'b0);
    chk("rst_spi_data", spi_data, 8'h00);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Two-byte command with exact start timing.
    push_tx(8'hA5);
    push_tx(8'h3C);
    chk("t1_tx_count", tx_count, 5'd2);
    d0 = done_cnt;
    do_go();
    @(negedge clk);
    chk("t1_start_n", spi_start, 1'b0);
    @(negedge clk);
    chk("t1_start_n1", spi_start, 1'b1);
    chk("t1_data_n1", spi_data, 8'hA5);
    @(negedge clk);
    chk("t1_start_n2", spi_start, 1'b0);
    chk("t1_data_hold", spi_data, 8'hA5);
    wait_end("t1");
    model_burst(1'b1);
    check_sent("t1");
    chk("t1_done_once", done_cnt - d0, 1);
    chk("t1_rx0", rx_data, 8'h5A);
    rx_drain("t1");

    // Random bursts, one extra byte queued while the burst is running.
    for (int r = 0; r < 4; r++) begin
      lat_max = 1 + r;
      n = int'($urandom_range(2, DEPTH - 1));
      for (int i = 0; i < n; i++) push_tx(8'($urandom));
      do_go();
      @(posedge clk);
      #1 push_tx(8'($urandom));
      wait_end($sformatf("rnd%0d", r));
      model_burst(1'b1);
      check_sent($sformatf("rnd%0d", r));
      chk($sformatf("rnd%0d_tx_count", r), tx_count, 5'(tx_m.size()));
      rx_drain($sformatf("rnd%0d", r));
    end

    // Full TX; the overflow byte must never be sent. RX ends up full.
    for (int i = 0; i < DEPTH; i++) push_tx(8'($urandom_range(0, 254)));
    push_tx(8'hFF);
    chk("full_tx_full", tx_full, 1'b1);
    chk("full_tx_count", tx_count, 5'(DEPTH));
    do_go();
    wait_end("full");
    model_burst(1'b1);
    check_sent("full");
    chk("full_tx_empty", tx_count, 5'd0);

    // RX full: the echo of 0x11 is dropped and rx_ovf sticks until the next accepted go.
    push_tx(8'h11);
    do_go();
    wait_end("ovf");
    model_burst(1'b1);
    check_sent("ovf");
    chk("ovf_set", rx_ovf, ovf_m);
    rx_drain("ovf");
    chk("ovf_sticky", rx_ovf, 1'b1);
    push_tx(8'h22);
    do_go();
    ovf_m = 1'b0;
    @(negedge clk);
    chk("ovf_cleared", rx_ovf, ovf_m);
    wait_end("ovfclr");
    model_burst(1'b1);
    check_sent("ovfclr");
    chk("ovfclr_stays", rx_ovf, ovf_m);
    rx_drain("ovfclr");

    // go with empty TX is ignored.
    d0 = done_cnt;
    do_go();
    repeat (6) @(posedge clk);
    #1;
    chk("empty_go_starts", sent_q.size(), 0);
    chk("empty_go_done", done_cnt - d0, 0);
    chk("empty_go_busy", busy, 1'b0);

    // go while busy is ignored.
    lat_max = 4;
    push_tx(8'h5C);
    push_tx(8'hC5);
    d0 = done_cnt;
    do_go();
    repeat (2) @(posedge clk);
    #1 do_go();
    wait_end("busygo");
    model_burst(1'b1);
    repeat (6) @(posedge clk);
    #1;
    check_sent("busygo");
    chk("busygo_done", done_cnt - d0, 1);
    chk("busygo_idle", busy, 1'b0);
    rx_drain("busygo");

    // Silent master: timeout exactly TIMEOUT cycles after WAIT entry, remaining bytes kept.
    master_on = 1'b0;
    for (int i = 0; i < 3; i++) push_tx(8'($urandom));
    d0 = done_cnt;
    do_go();
    @(negedge clk);
    @(negedge clk);
    cyc = 0;
    while (err_timeout !== 1'b1 && cyc < TIMEOUT + 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("to_latency", cyc, TIMEOUT);
    chk("to_busy_at_err", busy, 1'b1);
    @(negedge clk);
    chk("to_err_pulse", err_timeout, 1'b0);
    chk("to_idle", busy, 1'b0);
    chk("to_no_done", done_cnt - d0, 0);
    chk("to_tx_left", tx_count, 5'd2);
    chk("to_rx_empty", rx_empty, 1'b1);
    model_burst(1'b0);
    check_sent("to");
    @(posedge clk);
    #1;
    master_on = 1'b1;
    do_go();
    wait_end("to_rest");
    model_burst(1'b1);
    check_sent("to_rest");
    rx_drain("to_rest");

    // Reset in the middle of a 4-byte burst.
    master_on = 1'b0;
    for (int i = 0; i < 4; i++) push_tx(8'($urandom));
    do_go();
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_start", spi_start, 1'b0);
    chk("mid_rst_spi_data", spi_data, 8'h00);
    chk("mid_rst_tx_count", tx_count, 5'd0);
    chk("mid_rst_tx_full", tx_full, 1'b0);
    chk("mid_rst_rx_empty", rx_empty, 1'b1);
    chk("mid_rst_rx_data", rx_data, 8'h00);
    chk("mid_rst_done", done, 1'b0);
    chk("mid_rst_err", err_timeout, 1'b0);
    chk("mid_rst_ovf", rx_ovf, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    tx_m.delete();
    sent_q.delete();
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_idle", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
